// File: rtl/fc_layer_seq.sv
// fc_layer_seq: time-multiplexed fully-connected layer engine.
// A whole input vector is buffered, then every output neuron is computed
// with LANES signed MACs per cycle against a run-time loadable weight
// memory, and each result is streamed out over a valid/ready port.
module fc_layer_seq #(
    parameter  int WIDTH = 8,
    parameter  int IN    = 84,
    parameter  int OUT   = 10,
    parameter  int LANES = 4,
    parameter  int RELU  = 1,
    localparam int AW    = 2*WIDTH + $clog2(IN)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          w_we,
    input  logic [$clog2(OUT*IN)-1:0]     w_addr,
    input  logic signed [WIDTH-1:0]       w_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*WIDTH-1:0]        in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [AW-1:0]          out_data,
    output logic [$clog2(OUT)-1:0]        out_idx,
    output logic                          out_last,
    output logic                          busy
);

    localparam int C   = (IN + LANES - 1) / LANES;
    localparam int NW  = OUT * IN;
    localparam int WAW = $clog2(NW);
    localparam int XN  = C * LANES;
    localparam int XAW = (XN > 1) ? $clog2(XN) : 1;
    localparam int CW  = (C > 1) ? $clog2(C) : 1;
    localparam int OW  = $clog2(OUT);

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_EMIT    = 2'd2
    } state_t;

    state_t                  state_r;
    logic [CW-1:0]           b_r;
    logic [CW-1:0]           c_r;
    logic [OW-1:0]           o_r;
    logic signed [AW-1:0]    acc_r;
    logic signed [AW-1:0]    out_data_r;
    logic [OW-1:0]           out_idx_r;
    logic                    out_last_r;
    logic                    out_valid_r;
    logic                    busy_r;
    logic                    in_ready_r;

    // Weight memory and buffered input vector (padded to whole beats)
    logic signed [WIDTH-1:0] wmem_r [NW];
    logic signed [WIDTH-1:0] xbuf_r [XN];

    logic                    accept_s;
    logic                    w_ok_s;
    logic signed [WIDTH-1:0] lane_x_s    [LANES];
    logic [XAW-1:0]          lane_xaddr_s[LANES];
    logic signed [WIDTH-1:0] xrd_s;
    logic signed [WIDTH-1:0] wrd_s;
    logic signed [2*WIDTH-1:0] prod_s;
    logic signed [AW-1:0]    lane_sum_s;
    logic signed [AW-1:0]    fin_s;

    // Optional rectifier applied to the finished neuron value
    function automatic logic signed [AW-1:0] relu_f(input logic signed [AW-1:0] v);
        if ((RELU != 0) && v[AW-1]) begin
            return '0;
        end else begin
            return v;
        end
    endfunction

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_idx   = out_idx_r;
    assign out_last  = out_last_r;
    assign busy      = busy_r;

    assign accept_s = (state_r == ST_LOAD) && in_valid && in_ready_r;
    assign w_ok_s   = (state_r == ST_LOAD) && w_we &&
                      ({1'b0, w_addr} < (WAW+1)'(NW));

    // Steer incoming lanes to buffer slots; lanes past the vector end store zero
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            lane_xaddr_s[k] = XAW'(int'(b_r) * LANES + k);
            if (int'(b_r) * LANES + k < IN) begin
                lane_x_s[k] = in_data[k*WIDTH +: WIDTH];
            end else begin
                lane_x_s[k] = '0;
            end
        end
    end

    // One chunk of LANES signed MACs for neuron o_r, chunk c_r
    always_comb begin
        lane_sum_s = '0;
        xrd_s      = '0;
        wrd_s      = '0;
        prod_s     = '0;
        for (int k = 0; k < LANES; k++) begin
            if (int'(c_r) * LANES + k < IN) begin
                xrd_s  = xbuf_r[XAW'(int'(c_r) * LANES + k)];
                wrd_s  = wmem_r[WAW'(int'(o_r) * IN + int'(c_r) * LANES + k)];
                prod_s = (2*WIDTH)'(xrd_s) * (2*WIDTH)'(wrd_s);
            end else begin
                xrd_s  = '0;
                wrd_s  = '0;
                prod_s = '0;
            end
            lane_sum_s = lane_sum_s + AW'(prod_s);
        end
        fin_s = acc_r + lane_sum_s;
    end

    // Weight memory: written only while loading, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NW; i++) begin
                wmem_r[i] <= '0;
            end
        end else if (w_ok_s) begin
            wmem_r[w_addr] <= w_data;
        end
    end

    // Input vector buffer, filled one beat of LANES values at a time
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < XN; i++) begin
                xbuf_r[i] <= '0;
            end
        end else if (accept_s) begin
            for (int k = 0; k < LANES; k++) begin
                xbuf_r[lane_xaddr_s[k]] <= lane_x_s[k];
            end
        end
    end

    // Sequencer: load vector, accumulate each neuron, hold result until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_LOAD;
            b_r         <= '0;
            c_r         <= '0;
            o_r         <= '0;
            acc_r       <= '0;
            out_data_r  <= '0;
            out_idx_r   <= '0;
            out_last_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    in_ready_r <= 1'b1;
                    if (accept_s) begin
                        if (b_r == CW'(C - 1)) begin
                            b_r        <= '0;
                            c_r        <= '0;
                            o_r        <= '0;
                            acc_r      <= '0;
                            in_ready_r <= 1'b0;
                            busy_r     <= 1'b1;
                            state_r    <= ST_COMPUTE;
                        end else begin
                            b_r <= b_r + CW'(1);
                        end
                    end
                end
                ST_COMPUTE: begin
                    acc_r <= fin_s;
                    if (c_r == CW'(C - 1)) begin
                        out_data_r  <= relu_f(fin_s);
                        out_idx_r   <= o_r;
                        out_last_r  <= (o_r == OW'(OUT - 1));
                        out_valid_r <= 1'b1;
                        state_r     <= ST_EMIT;
                    end else begin
                        c_r <= c_r + CW'(1);
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        acc_r       <= '0;
                        c_r         <= '0;
                        if (o_r != OW'(OUT - 1)) begin
                            o_r     <= o_r + OW'(1);
                            state_r <= ST_COMPUTE;
                        end else begin
                            o_r        <= '0;
                            busy_r     <= 1'b0;
                            in_ready_r <= 1'b1;
                            state_r    <= ST_LOAD;
                        end
                    end
                end
                default: begin
                    state_r     <= ST_LOAD;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fc_layer_seq.sv
// Self-checking bench for fc_layer_seq: two 84-input/2-neuron instances
// (ReLU on and off) share one stimulus stream, and a 6-input/3-neuron
// instance exercises a partial final beat. Expected results come from a
// plain dot-product model over the bench's own weight/input arrays.
module tb_fc_layer_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    // Free-running edge counter used for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    // Shared stimulus for the 84-input instances
    logic       w_we;
    logic [7:0] w_addr;
    logic [7:0] w_data;
    logic       in_valid;
    logic [31:0] in_data;
    logic       out_ready;
    logic       a_in_ready, a_out_valid, a_out_last, a_busy;
    logic [22:0] a_out_data;
    logic [0:0]  a_out_idx;
    logic       b_in_ready, b_out_valid, b_out_last, b_busy;
    logic [22:0] b_out_data;
    logic [0:0]  b_out_idx;

    // Stimulus for the 6-input instance
    logic       c_w_we;
    logic [4:0] c_w_addr;
    logic [7:0] c_w_data;
    logic       c_in_valid;
    logic [31:0] c_in_data;
    logic       c_out_ready;
    logic       c_in_ready, c_out_valid, c_out_last, c_busy;
    logic [18:0] c_out_data;
    logic [1:0]  c_out_idx;

    fc_layer_seq #(.WIDTH(8), .IN(84), .OUT(2), .LANES(4), .RELU(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .out_idx(a_out_idx), .out_last(a_out_last), .busy(a_busy));

    fc_layer_seq #(.WIDTH(8), .IN(84), .OUT(2), .LANES(4), .RELU(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .out_idx(b_out_idx), .out_last(b_out_last), .busy(b_busy));

    fc_layer_seq #(.WIDTH(8), .IN(6), .OUT(3), .LANES(4), .RELU(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .w_we(c_w_we), .w_addr(c_w_addr), .w_data(c_w_data),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .out_idx(c_out_idx), .out_last(c_out_last), .busy(c_busy));

    int tests = 0;
    int fails = 0;

    int wm  [168];
    int xv  [84];
    int cwm [18];
    int cxv [6];

    task automatic check(input string tag, input longint obs, input longint exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int rnd8();
        return int'($urandom_range(255)) - 128;
    endfunction

    function automatic longint ref_ab(input int o, input bit relu);
        longint s = 0;
        for (int i = 0; i < 84; i++) s += longint'(xv[i]) * longint'(wm[o*84 + i]);
        if (relu && s < 0) s = 0;
        return s;
    endfunction

    function automatic longint ref_c(input int o);
        longint s = 0;
        for (int i = 0; i < 6; i++) s += longint'(cxv[i]) * longint'(cwm[o*6 + i]);
        if (s < 0) s = 0;
        return s;
    endfunction

    task automatic write_w(input int addr, input int val);
        w_we = 1'b1; w_addr = 8'(addr); w_data = 8'(val);
        @(posedge clk); #1;
        w_we = 1'b0;
        if (addr < 168) wm[addr] = val;
    endtask

    task automatic write_c(input int addr, input int val);
        c_w_we = 1'b1; c_w_addr = 5'(addr); c_w_data = 8'(val);
        @(posedge clk); #1;
        c_w_we = 1'b0;
        if (addr < 18) cwm[addr] = val;
    endtask

    task automatic send_ab(output int acc_cyc, output int first_wait);
        bit r;
        int w;
        first_wait = 0;
        for (int b = 0; b < 21; b++) begin
            for (int k = 0; k < 4; k++) in_data[k*8 +: 8] = 8'(xv[b*4 + k]);
            in_valid = 1'b1;
            w = 0;
            do begin
                @(negedge clk); r = a_in_ready; w++;
            end while (!r && w < 100);
            check("in_accept", longint'(r), 64'sd1);
            if (b == 0) first_wait = w - 1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        acc_cyc  = cyc;
    endtask

    task automatic collect_ab(input bit chk_lat, input int acc_cyc);
        int w;
        for (int o = 0; o < 2; o++) begin
            w = 0;
            do begin @(negedge clk); w++; end while (!a_out_valid && w < 200);
            check("a_valid", longint'(a_out_valid), 64'sd1);
            if (chk_lat && o == 0) check("latency", longint'(cyc - acc_cyc), 64'sd21);
            check("a_data", longint'($signed(a_out_data)), ref_ab(o, 1'b1));
            check("a_idx", longint'(a_out_idx), longint'(o));
            check("a_last", longint'(a_out_last), longint'(o == 1));
            check("b_valid", longint'(b_out_valid), 64'sd1);
            check("b_data", longint'($signed(b_out_data)), ref_ab(o, 1'b0));
            @(posedge clk); #1;
        end
    endtask

    task automatic send_c(input int junk);
        bit r;
        int w;
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 4; k++) begin
                if (b*4 + k < 6) c_in_data[k*8 +: 8] = 8'(cxv[b*4 + k]);
                else if (junk >= 0) c_in_data[k*8 +: 8] = 8'(junk);
                else c_in_data[k*8 +: 8] = 8'($urandom_range(255));
            end
            c_in_valid = 1'b1;
            w = 0;
            do begin
                @(negedge clk); r = c_in_ready; w++;
            end while (!r && w < 100);
            check("c_in_accept", longint'(r), 64'sd1);
            @(posedge clk); #1;
        end
        c_in_valid = 1'b0;
    endtask

    task automatic collect_c();
        int w;
        for (int o = 0; o < 3; o++) begin
            w = 0;
            do begin @(negedge clk); w++; end while (!c_out_valid && w < 100);
            check("c_valid", longint'(c_out_valid), 64'sd1);
            check("c_data", longint'($signed(c_out_data)), ref_c(o));
            check("c_idx", longint'(c_out_idx), longint'(o));
            check("c_last", longint'(c_out_last), longint'(o == 2));
            @(posedge clk); #1;
        end
    endtask

    // Hard time limit so the run always ends
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", tests, fails);
        $fatal(1, "watchdog");
    end

    // Main stimulus sequence
    initial begin
        int acc, fw, seen;
        rst_n = 1'b0; w_we = 1'b0; w_addr = '0; w_data = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        c_w_we = 1'b0; c_w_addr = '0; c_w_data = '0;
        c_in_valid = 1'b0; c_in_data = '0; c_out_ready = 1'b1;

        // Power-on reset values
        repeat (3) @(negedge clk);
        check("rst_in_ready", longint'(a_in_ready), 64'sd0);
        check("rst_valid", longint'(a_out_valid), 64'sd0);
        check("rst_busy", longint'(a_busy), 64'sd0);
        check("rst_data", longint'(a_out_data), 64'sd0);
        check("rst_c_in_ready", longint'(c_in_ready), 64'sd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        check("rel_in_ready", longint'(a_in_ready), 64'sd1);
        @(posedge clk); #1;

        // Directed: +1 / -1 neurons, x = 2 (expect 168 and 0 / -168)
        for (int i = 0; i < 84; i++) begin write_w(i, 1); write_w(84 + i, -1); end
        for (int i = 0; i < 84; i++) xv[i] = 2;
        send_ab(acc, fw);
        collect_ab(1'b1, acc);
        check("dir_ref0", ref_ab(0, 1'b1), 64'sd168);

        // Extremes: all -128 times -128 must not wrap
        for (int i = 0; i < 168; i++) write_w(i, -128);
        for (int i = 0; i < 84; i++) xv[i] = -128;
        send_ab(acc, fw);
        collect_ab(1'b1, acc);

        // Out-of-range address is ignored; then randomized vectors
        write_w(200, 5);
        for (int it = 0; it < 3; it++) begin
            for (int i = 0; i < 168; i++) write_w(i, rnd8());
            for (int i = 0; i < 84; i++) xv[i] = rnd8();
            if (it == 1) begin
                // Backpressure: EMIT holds for 5 cycles
                out_ready = 1'b0;
                send_ab(acc, fw);
                seen = 0;
                do begin @(negedge clk); seen++; end while (!a_out_valid && seen < 200);
                repeat (5) begin
                    @(negedge clk);
                    check("bp_valid", longint'(a_out_valid), 64'sd1);
                    check("bp_data", longint'($signed(a_out_data)), ref_ab(0, 1'b1));
                    check("bp_idx", longint'(a_out_idx), 64'sd0);
                    check("bp_busy", longint'(a_busy), 64'sd1);
                    check("bp_in_ready", longint'(a_in_ready), 64'sd0);
                end
                @(posedge clk); #1 out_ready = 1'b1;
                collect_ab(1'b0, 0);
            end else begin
                send_ab(acc, fw);
                collect_ab(1'b1, acc);
            end
        end

        // Back-to-back vectors with no gap
        for (int i = 0; i < 84; i++) xv[i] = rnd8();
        send_ab(acc, fw);
        collect_ab(1'b0, 0);
        for (int i = 0; i < 84; i++) xv[i] = rnd8();
        send_ab(acc, fw);
        check("b2b_first_wait", longint'(fw), 64'sd0);
        collect_ab(1'b1, acc);

        // Weight write during COMPUTE is dropped
        write_w(0, -7);
        for (int i = 0; i < 84; i++) xv[i] = rnd8();
        xv[0] = 50;
        send_ab(acc, fw);
        w_we = 1'b1; w_addr = 8'd0; w_data = 8'd55;
        repeat (3) @(posedge clk);
        #1 w_we = 1'b0;
        collect_ab(1'b0, 0);
        for (int i = 0; i < 84; i++) xv[i] = rnd8();
        xv[0] = 50;
        send_ab(acc, fw);
        collect_ab(1'b0, 0);

        // Reset in the middle of COMPUTE aborts the vector and clears weights
        for (int i = 0; i < 84; i++) xv[i] = rnd8();
        send_ab(acc, fw);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("mid_rst_valid", longint'(a_out_valid), 64'sd0);
            check("mid_rst_data", longint'(a_out_data), 64'sd0);
            check("mid_rst_busy", longint'(a_busy), 64'sd0);
            check("mid_rst_in_ready", longint'(a_in_ready), 64'sd0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        check("mid_rel_in_ready", longint'(a_in_ready), 64'sd1);
        seen = 0;
        repeat (30) begin @(negedge clk); if (a_out_valid) seen++; end
        check("abort_no_valid", longint'(seen), 64'sd0);
        for (int i = 0; i < 168; i++) wm[i] = 0;
        for (int i = 0; i < 18; i++) cwm[i] = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 84; i++) xv[i] = rnd8();
        send_ab(acc, fw);
        collect_ab(1'b0, 0);

        // Partial final beat: x = 1..6, weights 1, padding lanes = 127
        for (int i = 0; i < 18; i++) write_c(i, 1);
        for (int i = 0; i < 6; i++) cxv[i] = i + 1;
        send_c(127);
        collect_c();
        check("c_ref21", ref_c(0), 64'sd21);
        for (int it = 0; it < 3; it++) begin
            for (int i = 0; i < 18; i++) write_c(i, rnd8());
            for (int i = 0; i < 6; i++) cxv[i] = rnd8();
            send_c(-1);
            collect_c();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
